// File: rtl/axis_snoop_pkg.sv
// Shared types and helpers for the AXI-Stream snoop packet FIFO.
//   snoop_state_t : admission FSM states
//   sat_inc()     : saturating increment for statistics counters up to SAT_MAX_W bits
package axis_snoop_pkg;

    localparam int unsigned SAT_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCEPT  = 2'd1,
        DISCARD = 2'd2
    } snoop_state_t;

    // Increment the low 'width' bits of cnt, holding at all-ones once reached.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] cnt,
                                                     input int unsigned          width);
        logic [SAT_MAX_W-1:0] mask;
        logic [SAT_MAX_W-1:0] val;
        mask = (SAT_MAX_W'(1) << width) - SAT_MAX_W'(1);
        val  = cnt & mask;
        if (val == mask) begin
            sat_inc = val;
        end else begin
            sat_inc = (val + SAT_MAX_W'(1)) & mask;
        end
    endfunction

endpackage

// File: rtl/snoop_pkt_ram.sv
// Simple dual-port storage for the snoop FIFO: one synchronous write port,
// one asynchronous read port, contents not reset.
//   clk_i      : write clock
//   we_i       : write enable
//   waddr_i    : write address
//   wdata_i    : write data
//   raddr_i    : read address
//   rd_data_c  : read data (combinational from raddr_i)
module snoop_pkt_ram #(
    parameter int unsigned DEPTH  = 2048,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned WIDTH  = 9
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rd_data_c
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port (first-word fall-through source)
    assign rd_data_c = mem_q[raddr_i];

endmodule

// File: rtl/axis_snoop_pkt_fifo.sv
// Packet-mode FIFO behind a passive AXI-Stream snoop tap. Whole packets are
// admitted only when MAX_PKT_LEN beats are free at the first beat; a packet
// that overflows anyway is rolled back. Only committed packets are visible on
// the AXIS master side.
//   AXIS_ACLK / AXIS_ARESETN         : clock, async active-low reset
//   S_AXIS_*                         : snooped stream (observed only)
//   M_AXIS_*                         : committed-packet output, FWFT
//   FILL_LEVEL                       : committed occupancy in beats
//   ACCEPT/DROP/OVERSIZE_COUNT       : saturating packet statistics
module axis_snoop_pkt_fifo
    import axis_snoop_pkg::*;
#(
    parameter int unsigned PORT_WIDTH  = 8,
    parameter int unsigned DEPTH       = 2048,
    parameter int unsigned MAX_PKT_LEN = 1500,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                      AXIS_ACLK,
    input  logic                      AXIS_ARESETN,
    input  logic                      S_AXIS_TREADY,
    input  logic [PORT_WIDTH-1:0]     S_AXIS_TDATA,
    input  logic                      S_AXIS_TLAST,
    input  logic                      S_AXIS_TVALID,
    input  logic                      M_AXIS_TREADY,
    output logic [PORT_WIDTH-1:0]     M_AXIS_TDATA,
    output logic                      M_AXIS_TLAST,
    output logic                      M_AXIS_TVALID,
    output logic [$clog2(DEPTH):0]    FILL_LEVEL,
    output logic [CNT_WIDTH-1:0]      ACCEPT_COUNT,
    output logic [CNT_WIDTH-1:0]      DROP_COUNT,
    output logic [CNT_WIDTH-1:0]      OVERSIZE_COUNT
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned DW = PORT_WIDTH + 1;

    // Parameter sanity
    if (MAX_PKT_LEN > DEPTH) begin : g_bad_max_len
        $error("MAX_PKT_LEN must not exceed DEPTH");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end
    if (CNT_WIDTH > SAT_MAX_W || CNT_WIDTH == 0) begin : g_bad_cnt_w
        $error("CNT_WIDTH out of range");
    end

    snoop_state_t          state_q, state_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         wr_commit_q, wr_commit_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         fill_q, fill_d;
    logic [CNT_WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_WIDTH-1:0]  drop_q, drop_d;
    logic [CNT_WIDTH-1:0]  ovs_q, ovs_d;

    logic                  snoop_beat;
    logic                  full;
    logic                  admit;
    logic [PW-1:0]         free_beats;
    logic                  mem_we;
    logic                  rd_fire;
    logic [DW-1:0]         rd_data;

    assign snoop_beat = S_AXIS_TVALID & S_AXIS_TREADY;
    // Speculative pointer sees everything written, committed or not
    assign full       = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
    // Admission budget ignores any read in the same cycle (conservative)
    assign free_beats = PW'(DEPTH) - (wr_commit_q - rd_ptr_q);
    assign admit      = free_beats >= PW'(MAX_PKT_LEN);

    assign M_AXIS_TVALID = rd_ptr_q != wr_commit_q;
    assign rd_fire       = M_AXIS_TVALID & M_AXIS_TREADY;
    assign M_AXIS_TDATA  = rd_data[PORT_WIDTH-1:0];
    assign M_AXIS_TLAST  = rd_data[PORT_WIDTH];

    assign FILL_LEVEL     = fill_q;
    assign ACCEPT_COUNT   = acc_q;
    assign DROP_COUNT     = drop_q;
    assign OVERSIZE_COUNT = ovs_q;

    // Admission FSM, pointers and counters
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        acc_d       = acc_q;
        drop_d      = drop_q;
        ovs_d       = ovs_q;
        mem_we      = 1'b0;

        if (snoop_beat) begin
            case (state_q)
                IDLE: begin
                    if (admit) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        if (S_AXIS_TLAST) begin
                            wr_commit_d = wr_ptr_q + PW'(1);
                            acc_d       = CNT_WIDTH'(sat_inc(SAT_MAX_W'(acc_q), CNT_WIDTH));
                        end else begin
                            state_d = ACCEPT;
                        end
                    end else begin
                        drop_d = CNT_WIDTH'(sat_inc(SAT_MAX_W'(drop_q), CNT_WIDTH));
                        if (!S_AXIS_TLAST) begin
                            state_d = DISCARD;
                        end
                    end
                end
                ACCEPT: begin
                    if (!full) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PW'(1);
                        if (S_AXIS_TLAST) begin
                            wr_commit_d = wr_ptr_q + PW'(1);
                            acc_d       = CNT_WIDTH'(sat_inc(SAT_MAX_W'(acc_q), CNT_WIDTH));
                            state_d     = IDLE;
                        end
                    end else begin
                        // Packet outgrew storage: discard everything since last commit
                        wr_ptr_d = wr_commit_q;
                        ovs_d    = CNT_WIDTH'(sat_inc(SAT_MAX_W'(ovs_q), CNT_WIDTH));
                        state_d  = S_AXIS_TLAST ? IDLE : DISCARD;
                    end
                end
                DISCARD: begin
                    if (S_AXIS_TLAST) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        rd_ptr_d = rd_fire ? rd_ptr_q + PW'(1) : rd_ptr_q;
        // Registered occupancy tracks the pointers as they will be after this edge
        fill_d   = wr_commit_d - rd_ptr_d;
    end

    // State and pointer registers
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            acc_q       <= '0;
            drop_q      <= '0;
            ovs_q       <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            acc_q       <= acc_d;
            drop_q      <= drop_d;
            ovs_q       <= ovs_d;
        end
    end

    snoop_pkt_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (AW),
        .WIDTH  (DW)
    ) u_ram (
        .clk_i     (AXIS_ACLK),
        .we_i      (mem_we),
        .waddr_i   (wr_ptr_q[AW-1:0]),
        .wdata_i   ({S_AXIS_TLAST, S_AXIS_TDATA}),
        .raddr_i   (rd_ptr_q[AW-1:0]),
        .rd_data_c (rd_data)
    );

endmodule

// File: tb/tb_axis_snoop_pkt_fifo.sv
// Directed bench for axis_snoop_pkt_fifo (DEPTH=16, MAX_PKT_LEN=8, 4-bit counters).
module tb_axis_snoop_pkt_fifo;

    localparam int unsigned PW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned MAXL  = 8;
    localparam int unsigned CW    = 4;
    localparam int unsigned FW    = 5;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          s_ready = 1'b0;
    logic [PW-1:0] s_data  = '0;
    logic          s_last  = 1'b0;
    logic          s_valid = 1'b0;
    logic          m_ready = 1'b0;
    logic [PW-1:0] m_data;
    logic          m_last;
    logic          m_valid;
    logic [FW-1:0] fill;
    logic [CW-1:0] acc_cnt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] ovs_cnt;

    int unsigned   n_checks = 0;
    int unsigned   n_fail   = 0;
    bit            rand_ready = 1'b0;
    bit            ready_fix  = 1'b0;
    bit            seen_valid = 1'b0;
    logic [PW:0]   exp_q[$];
    int            exp_acc  = 0;
    int            exp_drop = 0;
    int            exp_ovs  = 0;

    axis_snoop_pkt_fifo #(
        .PORT_WIDTH  (PW),
        .DEPTH       (DEPTH),
        .MAX_PKT_LEN (MAXL),
        .CNT_WIDTH   (CW)
    ) dut (
        .AXIS_ACLK      (clk),
        .AXIS_ARESETN   (rst_n),
        .S_AXIS_TREADY  (s_ready),
        .S_AXIS_TDATA   (s_data),
        .S_AXIS_TLAST   (s_last),
        .S_AXIS_TVALID  (s_valid),
        .M_AXIS_TREADY  (m_ready),
        .M_AXIS_TDATA   (m_data),
        .M_AXIS_TLAST   (m_last),
        .M_AXIS_TVALID  (m_valid),
        .FILL_LEVEL     (fill),
        .ACCEPT_COUNT   (acc_cnt),
        .DROP_COUNT     (drop_cnt),
        .OVERSIZE_COUNT (ovs_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    // Downstream ready: fixed level or random per cycle
    always @(posedge clk) begin
        #1;
        m_ready = rand_ready ? 1'($urandom) : ready_fix;
    end

    // Output scoreboard: every transferred beat must be the next expected one
    always @(negedge clk) begin
        if (m_valid) seen_valid = 1'b1;
        if (rst_n && m_valid && m_ready) begin
            check_eq("out_beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check_eq("out_beat", 32'({m_last, m_data}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic drive_beat(input logic [PW-1:0] d, input logic last, input logic srdy);
        @(posedge clk);
        #1;
        s_valid = 1'b1;
        s_ready = srdy;
        s_data  = d;
        s_last  = last;
    endtask

    task automatic snoop_idle();
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Send len beats base, base+1, ...; optionally hold the first beat until
    // committed occupancy guarantees admission without overflow.
    task automatic send_pkt(input int len, input logic [PW-1:0] base, input bit expect_acc,
                            input bit wait_room);
        for (int i = 0; i < len; i++) begin
            @(posedge clk);
            #1;
            if (i == 0 && wait_room) begin
                int spins = 0;
                while (fill > FW'(DEPTH - MAXL) && spins < 200) begin
                    s_valid = 1'b0;
                    @(posedge clk);
                    #1;
                    spins++;
                end
                if (spins >= 200) check_eq("room_wait_timeout", 32'(spins), 32'd0);
            end
            s_valid = 1'b1;
            s_ready = 1'b1;
            s_data  = PW'(base + PW'(i));
            s_last  = (i == len - 1);
            if (expect_acc) exp_q.push_back({s_last, s_data});
        end
    endtask

    task automatic drain(input string tag);
        int spins = 0;
        ready_fix = 1'b1;
        while ((fill != 0 || exp_q.size() != 0) && spins < 400) begin
            @(negedge clk);
            spins++;
        end
        check_eq(tag, 32'(fill == 0 && exp_q.size() == 0), 32'd1);
        ready_fix = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_tvalid", 32'(m_valid), 32'd0);
        check_eq("rst_fill", 32'(fill), 32'd0);
        check_eq("rst_acc", 32'(acc_cnt), 32'd0);
        check_eq("rst_drop", 32'(drop_cnt), 32'd0);
        check_eq("rst_ovs", 32'(ovs_cnt), 32'd0);
        rst_n = 1'b1;
        ready_fix = 1'b1;
        repeat (2) @(posedge clk);

        // 1: 4-beat packet with ready high; an unready snoop cycle is ignored
        drive_beat(8'h11, 1'b0, 1'b1); exp_q.push_back({1'b0, 8'h11});
        drive_beat(8'h12, 1'b0, 1'b1); exp_q.push_back({1'b0, 8'h12});
        drive_beat(8'hEE, 1'b1, 1'b0);
        drive_beat(8'h13, 1'b0, 1'b1); exp_q.push_back({1'b0, 8'h13});
        drive_beat(8'h14, 1'b1, 1'b1); exp_q.push_back({1'b1, 8'h14});
        @(negedge clk);
        check_eq("t1_tvalid_before_commit", 32'(m_valid), 32'd0);
        snoop_idle();
        @(negedge clk);
        check_eq("t1_tvalid_after_last", 32'(m_valid), 32'd1);
        check_eq("t1_first_data", 32'(m_data), 32'h11);
        drain("t1_drain");
        exp_acc = 1;
        check_eq("t1_acc", 32'(acc_cnt), 32'(exp_acc));
        check_eq("t1_fill", 32'(fill), 32'd0);

        // 2: admission threshold with ready low
        send_pkt(5, 8'h20, 1'b1, 1'b0); snoop_idle();
        @(negedge clk);
        check_eq("t2_fill_a", 32'(fill), 32'd5);
        send_pkt(5, 8'h30, 1'b1, 1'b0); snoop_idle();
        @(negedge clk);
        check_eq("t2_fill_b", 32'(fill), 32'd10);
        send_pkt(5, 8'h40, 1'b0, 1'b0); snoop_idle();
        @(negedge clk);
        exp_acc += 2;
        exp_drop = 1;
        check_eq("t2_fill_c", 32'(fill), 32'd10);
        check_eq("t2_drop", 32'(drop_cnt), 32'(exp_drop));
        check_eq("t2_acc", 32'(acc_cnt), 32'(exp_acc));
        // Drop counter saturation
        for (int i = 0; i < 16; i++) begin
            drive_beat(PW'(8'h50 + i), 1'b1, 1'b1);
            exp_drop = sat15(exp_drop + 1);
        end
        snoop_idle();
        @(negedge clk);
        check_eq("t2_drop_sat", 32'(drop_cnt), 32'(exp_drop));
        drain("t2_drain");

        // 3: oversize packet rolled back, never visible
        @(negedge clk);
        seen_valid = 1'b0;
        send_pkt(20, 8'h80, 1'b0, 1'b0); snoop_idle();
        repeat (2) @(negedge clk);
        exp_ovs = 1;
        check_eq("t3_ovs", 32'(ovs_cnt), 32'(exp_ovs));
        check_eq("t3_fill", 32'(fill), 32'd0);
        check_eq("t3_never_valid", 32'(seen_valid), 32'd0);
        send_pkt(3, 8'h60, 1'b1, 1'b0); snoop_idle();
        @(negedge clk);
        exp_acc += 1;
        check_eq("t3_fill_small", 32'(fill), 32'd3);
        drain("t3_drain_small");
        // Packet exactly filling storage
        send_pkt(16, 8'h70, 1'b1, 1'b0); snoop_idle();
        @(negedge clk);
        exp_acc += 1;
        check_eq("t3_fill_full", 32'(fill), 32'd16);
        check_eq("t3_ovs_full", 32'(ovs_cnt), 32'(exp_ovs));
        check_eq("t3_acc_full", 32'(acc_cnt), 32'(exp_acc));
        drain("t3_drain_full");

        // 4: 1-beat packet right after a discarded TLAST
        send_pkt(18, 8'h90, 1'b0, 1'b0);
        send_pkt(1, 8'h5A, 1'b1, 1'b0);
        snoop_idle();
        @(negedge clk);
        exp_ovs += 1;
        exp_acc += 1;
        check_eq("t4_ovs", 32'(ovs_cnt), 32'(exp_ovs));
        check_eq("t4_acc", 32'(acc_cnt), 32'(exp_acc));
        check_eq("t4_fill", 32'(fill), 32'd1);
        check_eq("t4_tlast", 32'(m_last), 32'd1);
        check_eq("t4_data", 32'(m_data), 32'h5A);
        drain("t4_drain");

        // 5: back-to-back packets with random downstream ready
        rand_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            send_pkt(int'($urandom_range(1, 8)), PW'(k * 7), 1'b1, 1'b1);
            exp_acc = sat15(exp_acc + 1);
        end
        snoop_idle();
        rand_ready = 1'b0;
        drain("t5_drain");
        check_eq("t5_acc_sat", 32'(acc_cnt), 32'(exp_acc));
        check_eq("t5_drop", 32'(drop_cnt), 32'(exp_drop));

        // 6: asynchronous reset mid-packet with committed data present
        send_pkt(6, 8'hB0, 1'b1, 1'b0); snoop_idle();
        drive_beat(8'hC0, 1'b0, 1'b1);
        drive_beat(8'hC1, 1'b0, 1'b1);
        drive_beat(8'hC2, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_tvalid", 32'(m_valid), 32'd0);
        check_eq("t6_rst_fill", 32'(fill), 32'd0);
        check_eq("t6_rst_acc", 32'(acc_cnt), 32'd0);
        check_eq("t6_rst_drop", 32'(drop_cnt), 32'd0);
        check_eq("t6_rst_ovs", 32'(ovs_cnt), 32'd0);
        exp_q.delete();
        exp_acc = 0; exp_drop = 0; exp_ovs = 0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive_beat(8'hD0, 1'b0, 1'b1); exp_q.push_back({1'b0, 8'hD0});
        drive_beat(8'hD1, 1'b1, 1'b1); exp_q.push_back({1'b1, 8'hD1});
        snoop_idle();
        @(negedge clk);
        exp_acc = 1;
        check_eq("t6_post_acc", 32'(acc_cnt), 32'(exp_acc));
        check_eq("t6_post_fill", 32'(fill), 32'd2);
        drain("t6_drain");
        check_eq("t6_post_ovs", 32'(ovs_cnt), 32'(exp_ovs));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_snoop_pkt_fifo.md
Name: axis_snoop_pkt_fifo

Overview:
Parametrised packet-mode FIFO for a passive AXI-Stream snoop tap. It has no backpressure on the snoop side.
- Admits whole packets only when space for MAX_PKT_LEN beats is free at the first beat.
- Rolls back any admitted packet that overflows storage.
- Exposes only fully committed packets on a standard AXIS master, with inferred storage (no vendor IP).
- Adds occupancy and saturating drop/oversize/accept counters for the monitoring path.

Parameters:
PORT_WIDTH, 8, TDATA width in bits
DEPTH, 2048, storage entries (beats); power of two
MAX_PKT_LEN, 1500, admission threshold in beats; must be <= DEPTH (elaboration error otherwise)
CNT_WIDTH, 32, width of statistics counters

Ports:
AXIS_ACLK  in  1  clock
AXIS_ARESETN  in  1  asynchronous active-low reset
S_AXIS_TREADY  in  1  snooped ready
S_AXIS_TDATA  in  PORT_WIDTH  snooped data
S_AXIS_TLAST  in  1  snooped last
S_AXIS_TVALID  in  1  snooped valid
M_AXIS_TREADY  in  1  downstream ready
M_AXIS_TDATA  out  PORT_WIDTH  output data
M_AXIS_TLAST  out  1  output last
M_AXIS_TVALID  out  1  committed data available
FILL_LEVEL  out  $clog2(DEPTH)+1  committed occupancy (beats)
ACCEPT_COUNT  out  CNT_WIDTH  packets committed, saturating
DROP_COUNT  out  CNT_WIDTH  packets refused at admission, saturating
OVERSIZE_COUNT  out  CNT_WIDTH  packets rolled back mid-packet, saturating

Behaviour:
- Snoop beat: S_AXIS_TVALID & S_AXIS_TREADY. Every beat is consumed; no ready is returned.
- Storage:
  - mem[DEPTH] of {TLAST, TDATA}.
  - Pointers are $clog2(DEPTH)+1 bits with wrap bit: wr_ptr (speculative), wr_commit, rd_ptr.
  - full = (wr_ptr - rd_ptr) == DEPTH. free = DEPTH - (wr_commit - rd_ptr).
- FSM states: IDLE (expect first beat), ACCEPT, DISCARD.
- IDLE + beat:
  - If free >= MAX_PKT_LEN, write mem[wr_ptr] and increment wr_ptr. On TLAST, commit: wr_commit <= wr_ptr+1, ACCEPT_COUNT++, stay IDLE. Otherwise go to ACCEPT.
  - Else DROP_COUNT++. On TLAST stay IDLE, otherwise go to DISCARD.
- ACCEPT + beat:
  - If not full, write and increment. On TLAST, commit, ACCEPT_COUNT++, go to IDLE.
  - If full, do not write. Set wr_ptr <= wr_commit (rollback) and OVERSIZE_COUNT++. On TLAST go to IDLE, otherwise go to DISCARD.
- DISCARD + beat: no write. On TLAST go to IDLE.
- Admission uses registered rd_ptr of the current cycle. A read in the same cycle is not credited, so admission is conservative.
- Output is first-word fall-through:
  - M_AXIS_TVALID = (rd_ptr != wr_commit); M_AXIS_TDATA/TLAST = mem[rd_ptr].
  - rd_ptr increments on M_AXIS_TVALID & M_AXIS_TREADY.
  - A beat committed at edge N is visible after edge N (latency 1 cycle from the TLAST beat).
- The output never shows uncommitted or rolled-back data. Packets leave in arrival order, and each contains exactly the snooped beats.
- Commit, rollback and read may occur in the same cycle; each pointer has a single writer, so there is no conflict.
- FILL_LEVEL = wr_commit - rd_ptr, registered.
- Counters saturate at all-ones.
- Reset (asynchronous, any time including mid-packet):
  - Pointers to 0, state IDLE, counters to 0.
  - M_AXIS_TVALID=0, FILL_LEVEL=0.
  - M_AXIS_TDATA/TLAST are don't-care while TVALID=0.
  - Memory contents are not reset.
- After reset deasserts mid-packet, the next beat is treated as a first beat.

Decomposition:
- Package axis_snoop_pkg: snoop_state_t enum {IDLE, ACCEPT, DISCARD}; function sat_inc(cnt) for counters.
- Sub-module snoop_pkt_ram: simple dual-port, one write port, asynchronous read, DEPTH x (PORT_WIDTH+1), no reset.
- The FSM, pointers and counters stay in the top level.

Test Plan:
1. Reset, then a 4-beat packet (data 0x11..0x14) with M_AXIS_TREADY=1 -> M_AXIS_TVALID rises the cycle after the TLAST beat; 0x11..0x14 out with TLAST on 0x14; ACCEPT_COUNT=1; FILL_LEVEL returns to 0.
2. DEPTH=16, MAX_PKT_LEN=8, M_AXIS_TREADY=0: three 5-beat packets -> first accepted (FILL_LEVEL=5), second accepted (10), third dropped (DROP_COUNT=1, FILL_LEVEL stays 10).
3. DEPTH=16, MAX_PKT_LEN=8, ready=0: one 20-beat packet -> OVERSIZE_COUNT=1, FILL_LEVEL=0, M_AXIS_TVALID never asserts. A following 3-beat packet is accepted and output intact.
4. Packet in DISCARD with TLAST, next cycle a 1-beat packet with TLAST -> the 1-beat packet is committed; ACCEPT_COUNT increments; its output beat has TLAST=1.
5. Toggling M_AXIS_TREADY randomly while back-to-back packets stream in with rd_ptr wrapping past DEPTH -> output beat sequence equals the accepted packets in order; no beat duplicated or lost.
6. Assert AXIS_ARESETN low asynchronously mid-packet with 6 beats committed -> M_AXIS_TVALID=0 and all counters=0 immediately; post-reset traffic is handled normally.
